// File: rtl/byte_demux16.sv
// byte_demux16: collects 16 bytes from an 8-bit AES datapath into a
// 128-bit state block and presents it with a valid/ready handshake.
// A two-state FSM (FILL / HOLD) owns the flow control; in HOLD the
// assembled block is frozen until the consumer takes it or clear flushes it.
// Optional feature: define DEMUX_BLKCNT_EN to add an 8-bit count of
// completed output handshakes on port blk_cnt.
module byte_demux16 #(
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   byte_idx
`ifdef DEMUX_BLKCNT_EN
  ,
  output logic [7:0]   blk_cnt
`endif
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [3:0]     r_byte_idx;
  logic [127:0]   r_out_block;
  logic           w_accept;
  logic           w_handshake;
  logic           w_last_byte;
  logic [6:0]     w_slot_lo;

  // Bit offset of the low bit of slot idx inside the 128-bit block.
  // LSB_FIRST places slot 0 at the bottom; otherwise slot 0 sits at the top
  // so the first byte received becomes the most significant byte.
  function automatic logic [6:0] slot_lo(input logic [3:0] idx);
    logic [6:0] lo;
    lo = {idx, 3'b000};
    if (LSB_FIRST != 0) begin
      slot_lo = lo;
    end else begin
      slot_lo = 7'd120 - lo;
    end
  endfunction

  assign w_slot_lo   = slot_lo(r_byte_idx);
  assign w_last_byte = (r_byte_idx == 4'd15);

  // Flow-control decode depends on state only, never on the inputs.
  assign in_ready  = (r_state == ST_FILL);
  assign out_valid = (r_state == ST_HOLD);
  assign out_block = r_out_block;
  assign byte_idx  = r_byte_idx;

  // Next-state and event decode; clear overrides both accept and handshake.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    if (clear) begin
      w_state_next = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (in_valid) begin
            w_accept = 1'b1;
            if (w_last_byte) begin
              w_state_next = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            w_handshake  = 1'b1;
            w_state_next = ST_FILL;
          end
        end
        default: begin
          w_state_next = ST_FILL;
        end
      endcase
    end
  end

  // State register; reset drops any partial or complete block immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Slot pointer: rewinds on clear, advances on each accepted byte and
  // wraps from 15 to 0 as the block completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx <= 4'd0;
    end else if (clear) begin
      r_byte_idx <= 4'd0;
    end else if (w_accept) begin
      r_byte_idx <= r_byte_idx + 4'd1;
    end
  end

  // Block storage: only the addressed slot is written; the other slots keep
  // whatever the previous block left there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_block <= 128'h0;
    end else if (w_accept) begin
      r_out_block[w_slot_lo +: 8] <= in_byte;
    end
  end

`ifdef DEMUX_BLKCNT_EN
  logic [7:0] r_blk_cnt;

  assign blk_cnt = r_blk_cnt;

  // Completed-handshake counter; clear never counts as a delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= 8'd0;
    end else if (w_handshake) begin
      r_blk_cnt <= r_blk_cnt + 8'd1;
    end
  end
`else
  logic w_unused_handshake;
  assign w_unused_handshake = w_handshake;
`endif

endmodule

// File: tb/tb_byte_demux16.sv
// Self-checking bench for byte_demux16: one instance per byte order, both
// driven from the same stimulus, compared against a byte-array model.
module tb_byte_demux16;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready_l, in_ready_m;
  logic [127:0] out_block_l, out_block_m;
  logic         out_valid_l, out_valid_m;
  logic [3:0]   byte_idx_l, byte_idx_m;
`ifdef DEMUX_BLKCNT_EN
  logic [7:0]   blk_cnt_l, blk_cnt_m;
`endif

  int errors = 0;
  int checks = 0;

  // reference model: plain byte array, fill pointer, full flag, block count
  logic [7:0] m_bytes [16];
  int         m_idx;
  bit         m_full;
  int         m_cnt;

  byte_demux16 #(.LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready_l), .out_block(out_block_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .byte_idx(byte_idx_l)
`ifdef DEMUX_BLKCNT_EN
    , .blk_cnt(blk_cnt_l)
`endif
  );

  byte_demux16 #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready_m), .out_block(out_block_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .byte_idx(byte_idx_m)
`ifdef DEMUX_BLKCNT_EN
    , .blk_cnt(blk_cnt_m)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] exp_blk(input bit lsb);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      if (lsb) b[8*k +: 8] = m_bytes[k];
      else     b[120 - 8*k +: 8] = m_bytes[k];
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_bytes[k] = 8'h00;
    m_idx  = 0;
    m_full = 0;
    m_cnt  = 0;
  endtask

  // apply the current inputs to the model, then advance one clock
  task automatic step();
    if (clear) begin
      m_idx  = 0;
      m_full = 0;
    end else if (!m_full) begin
      if (in_valid) begin
        m_bytes[m_idx] = in_byte;
        if (m_idx == 15) m_full = 1;
        m_idx = (m_idx + 1) % 16;
      end
    end else if (out_ready) begin
      m_full = 0;
      m_cnt  = (m_cnt + 1) % 256;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clear = 1'b0; in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (out_block_l !== 128'h0 || out_block_m !== 128'h0) begin
      errors++; $display("FAIL reset_block got=%h/%h exp=0", out_block_l, out_block_m);
    end
    checks++;
    if ({out_valid_l, in_ready_l, byte_idx_l} !== 6'b010000) begin
      errors++; $display("FAIL reset_ctrl got v=%b r=%b idx=%0d exp v=0 r=1 idx=0",
                         out_valid_l, in_ready_l, byte_idx_l);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_order();
    for (int b = 0; b < 16; b++) begin
      in_valid = 1'b1;
      in_byte  = 8'(b);
      step();
      if (b == 14) begin
        checks++;
        if (out_valid_l !== 1'b0) begin
          errors++; $display("FAIL fill_early_valid got=%b exp=0", out_valid_l);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid_l !== 1'b1 || out_valid_m !== 1'b1) begin
      errors++; $display("FAIL fill_valid got=%b/%b exp=1", out_valid_l, out_valid_m);
    end
    checks++;
    if (out_block_l !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      errors++; $display("FAIL fill_lsb_block got=%h exp=0f0e0d0c0b0a09080706050403020100", out_block_l);
    end
    checks++;
    if (out_block_m !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errors++; $display("FAIL fill_msb_block got=%h exp=000102030405060708090a0b0c0d0e0f", out_block_m);
    end
    checks++;
    if (in_ready_l !== 1'b0 || byte_idx_l !== 4'd0) begin
      errors++; $display("FAIL fill_ready_idx got r=%b idx=%0d exp r=0 idx=0", in_ready_l, byte_idx_l);
    end
  endtask

  task automatic test_hold();
    logic [127:0] held;
    held      = 128'h0F0E0D0C0B0A09080706050403020100;
    in_valid  = 1'b1;
    in_byte   = 8'hFF;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (out_block_l !== held || byte_idx_l !== 4'd0 || out_valid_l !== 1'b1) begin
        errors++; $display("FAIL hold_stable c=%0d got=%h idx=%0d v=%b exp=%h idx=0 v=1",
                           c, out_block_l, byte_idx_l, out_valid_l, held);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0 || out_block_l !== held) begin
      errors++; $display("FAIL hold_handshake got r=%b v=%b blk=%h exp r=1 v=0 blk=%h",
                         in_ready_l, out_valid_l, out_block_l, held);
    end
    in_byte = 8'hAB;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_block_l[7:0] !== 8'hAB || out_block_m[127:120] !== 8'hAB || byte_idx_l !== 4'd1) begin
      errors++; $display("FAIL hold_slot0 got=%h/%h idx=%0d exp=ab/ab idx=1",
                         out_block_l[7:0], out_block_m[127:120], byte_idx_l);
    end
    checks++;
    if (out_block_l[15:8] !== 8'h01) begin
      errors++; $display("FAIL retain_slot1 got=%h exp=01", out_block_l[15:8]);
    end
  endtask

  task automatic test_clear();
    logic [127:0] saved;
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      step();
    end
    checks++;
    if (byte_idx_l !== 4'd7) begin
      errors++; $display("FAIL clear_pre_idx got=%0d exp=7", byte_idx_l);
    end
    saved   = out_block_l;
    in_byte = 8'h5A;
    clear   = 1'b1;
    step();
    clear   = 1'b0;
    checks++;
    if (byte_idx_l !== 4'd0 || out_block_l !== saved || out_block_l !== exp_blk(1)) begin
      errors++; $display("FAIL clear_nowrite got idx=%0d blk=%h exp idx=0 blk=%h",
                         byte_idx_l, out_block_l, saved);
    end
    for (int b = 0; b < 16; b++) begin
      in_byte = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid_l !== 1'b1 || out_block_l !== exp_blk(1) || out_block_m !== exp_blk(0)) begin
      errors++; $display("FAIL clear_refill got v=%b blk=%h exp v=1 blk=%h",
                         out_valid_l, out_block_l, exp_blk(1));
    end
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0 || byte_idx_l !== 4'd0) begin
      errors++; $display("FAIL clear_in_hold got r=%b v=%b idx=%0d exp r=1 v=0 idx=0",
                         in_ready_l, out_valid_l, byte_idx_l);
    end
`ifdef DEMUX_BLKCNT_EN
    checks++;
    if (blk_cnt_l !== 8'(m_cnt)) begin
      errors++; $display("FAIL clear_blkcnt got=%0d exp=%0d", blk_cnt_l, m_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    for (int b = 0; b < 9; b++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom_range(1, 255));
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (byte_idx_l !== 4'd9) begin
      errors++; $display("FAIL areset_pre_idx got=%0d exp=9", byte_idx_l);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_block_l !== 128'h0 || out_block_m !== 128'h0 || out_valid_l !== 1'b0 ||
        byte_idx_l !== 4'd0 || in_ready_l !== 1'b1) begin
      errors++; $display("FAIL areset_immediate got blk=%h v=%b idx=%0d r=%b exp blk=0 v=0 idx=0 r=1",
                         out_block_l, out_valid_l, byte_idx_l, in_ready_l);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h3C;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_block_l !== 128'h3C || byte_idx_l !== 4'd1) begin
      errors++; $display("FAIL areset_first_slot got=%h idx=%0d exp=3c idx=1", out_block_l, byte_idx_l);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clear     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      in_byte   = 8'($urandom);
      step();
      checks++;
      if (out_block_l !== exp_blk(1) || out_block_m !== exp_blk(0)) begin
        errors++; $display("FAIL rand_block c=%0d got=%h/%h exp=%h/%h",
                           c, out_block_l, out_block_m, exp_blk(1), exp_blk(0));
      end
      checks++;
      if ({out_valid_l, in_ready_l, byte_idx_l, out_valid_m, in_ready_m, byte_idx_m} !==
          {m_full, !m_full, 4'(m_idx), m_full, !m_full, 4'(m_idx)}) begin
        errors++; $display("FAIL rand_ctrl c=%0d got v=%b r=%b idx=%0d exp v=%b r=%b idx=%0d",
                           c, out_valid_l, in_ready_l, byte_idx_l, m_full, !m_full, m_idx);
      end
`ifdef DEMUX_BLKCNT_EN
      checks++;
      if (blk_cnt_l !== 8'(m_cnt) || blk_cnt_m !== 8'(m_cnt)) begin
        errors++; $display("FAIL rand_blkcnt c=%0d got=%0d exp=%0d", c, blk_cnt_l, m_cnt);
      end
`endif
    end
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

`ifdef DEMUX_BLKCNT_EN
  task automatic test_blkcnt();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 257; n++) begin
      in_valid = 1'b1;
      for (int b = 0; b < 16; b++) begin
        in_byte = 8'($urandom);
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    checks++;
    if (blk_cnt_l !== 8'd1 || blk_cnt_l !== 8'(m_cnt)) begin
      errors++; $display("FAIL blkcnt_wrap got=%0d exp=1", blk_cnt_l);
    end
    in_valid = 1'b1;
    for (int b = 0; b < 16; b++) begin
      in_byte = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    checks++;
    if (blk_cnt_l !== 8'd1 || out_valid_l !== 1'b0) begin
      errors++; $display("FAIL blkcnt_clear got cnt=%0d v=%b exp cnt=1 v=0", blk_cnt_l, out_valid_l);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_order();
    test_hold();
    test_clear();
    test_async_reset();
    test_random();
`ifdef DEMUX_BLKCNT_EN
    test_blkcnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
